// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM for the lab CPU: sequences fetch, decode, execute,
// memory access and write-back, drives ALU operation/operand selects and all
// datapath write enables. Optional performance counters are built in when
// MC_CTRL_PERF_CNT_EN is defined.
module mc_ctrl_fsm (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] inst,
    input  logic        alu_zero,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    output logic        inst_req,
    output logic        data_req,
    output logic        data_wr,
    output logic [2:0]  alu_op,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        pc_write,
    output logic        ir_write,
    output logic        mdr_write,
    output logic        reg_write,
    output logic [1:0]  pc_src,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic [2:0]  state
`ifdef MC_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] inst_cnt
`endif
);

    typedef enum logic [2:0] {
        StIf = 3'd0,
        StIw = 3'd1,
        StId = 3'd2,
        StEx = 3'd3,
        StMa = 3'd4,
        StMw = 3'd5,
        StWb = 3'd6
    } state_e;

    localparam logic [2:0] AluAnd   = 3'b000;
    localparam logic [2:0] AluOr    = 3'b001;
    localparam logic [2:0] AluAdd   = 3'b010;
    localparam logic [2:0] AluLui   = 3'b011;
    localparam logic [2:0] AluSll   = 3'b100;
    localparam logic [2:0] AluSltiu = 3'b101;
    localparam logic [2:0] AluSub   = 3'b110;
    localparam logic [2:0] AluSlt   = 3'b111;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddiu = 6'b001001;
    localparam logic [5:0] OpSltiu = 6'b001011;
    localparam logic [5:0] OpLui   = 6'b001111;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    localparam logic [5:0] FnSll  = 6'b000000;
    localparam logic [5:0] FnAddu = 6'b100001;
    localparam logic [5:0] FnSubu = 6'b100011;
    localparam logic [5:0] FnAnd  = 6'b100100;
    localparam logic [5:0] FnOr   = 6'b100101;
    localparam logic [5:0] FnSlt  = 6'b101010;

    state_e state_q, state_d;

    logic [5:0] opcode, funct;
    logic       is_rtype, r_ok, i_alu, is_lw, is_sw, is_beq, is_bne, is_j;
    logic       unused_inst;

    assign opcode   = inst[31:26];
    assign funct    = inst[5:0];
    assign is_rtype = (opcode == OpRtype);
    assign r_ok     = is_rtype && (funct inside {FnSll, FnAddu, FnSubu, FnAnd, FnOr, FnSlt});
    assign i_alu    = opcode inside {OpAddiu, OpSltiu, OpLui};
    assign is_lw    = (opcode == OpLw);
    assign is_sw    = (opcode == OpSw);
    assign is_beq   = (opcode == OpBeq);
    assign is_bne   = (opcode == OpBne);
    assign is_j     = (opcode == OpJ);
    // Register/immediate fields are consumed by the datapath, not here.
    assign unused_inst = ^inst[25:6];

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIf;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; everything forced to 0 while in reset.
    always_comb begin
        state_d    = state_q;
        inst_req   = 1'b0;
        data_req   = 1'b0;
        data_wr    = 1'b0;
        alu_op     = AluAdd;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mdr_write  = 1'b0;
        reg_write  = 1'b0;
        pc_src     = 2'd0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        state      = state_q;

        case (state_q)
            StIf: begin
                inst_req  = 1'b1;
                alu_src_b = 2'd1;
                if (inst_addr_ok) state_d = StIw;
            end
            StIw: begin
                alu_src_b = 2'd1;
                if (inst_data_ok) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StId;
                end
            end
            StId: begin
                // Branch target PC + (imm << 2) lands in ALUOut for EX to use.
                alu_src_b = 2'd3;
                if (is_j) begin
                    pc_write = 1'b1;
                    pc_src   = 2'd2;
                    state_d  = StIf;
                end else if (r_ok || i_alu || is_lw || is_sw || is_beq || is_bne) begin
                    state_d = StEx;
                end else begin
                    state_d = StIf;
                end
            end
            StEx: begin
                state_d = StIf;
                if (r_ok) begin
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd0;
                    state_d   = StWb;
                    case (funct)
                        FnSll: begin
                            alu_op    = AluSll;
                            alu_src_a = 2'd2;
                        end
                        FnSubu:  alu_op = AluSub;
                        FnAnd:   alu_op = AluAnd;
                        FnOr:    alu_op = AluOr;
                        FnSlt:   alu_op = AluSlt;
                        default: alu_op = AluAdd;
                    endcase
                end else if (i_alu) begin
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd2;
                    state_d   = StWb;
                    if (opcode == OpSltiu)    alu_op = AluSltiu;
                    else if (opcode == OpLui) alu_op = AluLui;
                    else                      alu_op = AluAdd;
                end else if (is_lw || is_sw) begin
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd2;
                    state_d   = StMa;
                end else if (is_beq || is_bne) begin
                    alu_op    = AluSub;
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd0;
                    pc_src    = 2'd1;
                    pc_write  = is_beq ? alu_zero : !alu_zero;
                end
            end
            StMa: begin
                data_req = 1'b1;
                data_wr  = is_sw;
                if (data_addr_ok) state_d = StMw;
            end
            StMw: begin
                if (data_data_ok) begin
                    if (is_lw) begin
                        mdr_write = 1'b1;
                        state_d   = StWb;
                    end else begin
                        state_d = StIf;
                    end
                end
            end
            StWb: begin
                reg_write  = 1'b1;
                reg_dst    = is_rtype;
                mem_to_reg = is_lw;
                state_d    = StIf;
            end
            default: state_d = StIf;
        endcase

        if (!resetn) begin
            inst_req   = 1'b0;
            data_req   = 1'b0;
            data_wr    = 1'b0;
            alu_op     = 3'd0;
            alu_src_a  = 2'd0;
            alu_src_b  = 2'd0;
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mdr_write  = 1'b0;
            reg_write  = 1'b0;
            pc_src     = 2'd0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            state      = 3'd0;
        end
    end

`ifdef MC_CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] inst_cnt_q, inst_cnt_d;
    logic        inst_done;

    // Counter next-state: an instruction retires when control returns to IF.
    always_comb begin
        inst_done   = (state_d == StIf) && (state_q inside {StId, StEx, StMw, StWb});
        cycle_cnt_d = cycle_cnt_q + 32'd1;
        inst_cnt_d  = inst_cnt_q + (inst_done ? 32'd1 : 32'd0);
    end

    // Counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cycle_cnt_q <= 32'd0;
            inst_cnt_q  <= 32'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            inst_cnt_q  <= inst_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign inst_cnt  = inst_cnt_q;
`endif

endmodule
